// File: rtl/rv_mc_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, state
// encoding, writeback-select and trap-cause codes, and opcode classifiers.
package rv_mc_seq_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_TIMEOUT = 2'b01,
    CAUSE_ILLEGAL = 2'b10
  } trap_cause_t;

  // Opcodes this core can execute; anything else traps in DECODE.
  function automatic logic is_legal_opc(input logic [6:0] opc);
    return (opc == OPC_R)     || (opc == OPC_I)      || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JAL);
  endfunction

  // Instruction classes whose ALU second operand is the immediate.
  function automatic logic uses_imm(input logic [6:0] opc);
    return (opc == OPC_I) || (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/rv_mc_seq_if.sv
// Single shared instruction/data memory port between sequencer and memory.
interface rv_mc_seq_if;
  logic mem_req_o;  // request held until ack or timeout
  logic mem_we_o;   // 1 = store
  logic mem_sel_o;  // 0 = PC address, 1 = ALU result address
  logic mem_ack_i;  // one-cycle completion pulse

  modport master (output mem_req_o, output mem_we_o, output mem_sel_o,
                  input  mem_ack_i);
  modport slave  (input  mem_req_o, input  mem_we_o, input  mem_sel_o,
                  output mem_ack_i);
endinterface

// File: rtl/rv_mc_seq_timer.sv
// Memory-wait watchdog: counts consecutive un-acked request cycles and flags
// the last allowed one. Counter returns to zero whenever no wait is pending,
// so every FETCH/MEM entry starts from a clean count.
module rv_mc_seq_timer #(
  parameter int unsigned LIMIT = 16  // >= 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic run_i,     // request outstanding and not acked this cycle
  output logic expire_o   // this is the LIMIT-th un-acked cycle
);

  localparam int unsigned   W    = $clog2(LIMIT);
  localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear when idle, otherwise saturate at LAST.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = '0;
    if (run_i) begin
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking updates keep all flops sampling pre-edge values.
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/rv_mc_seq.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB over one
// shared memory port, with memory timeout and illegal-opcode traps and a
// retired-instruction counter. Strobes are decoded combinationally from the
// registered state so the IR load can coincide with the fetch ack.
module rv_mc_seq
  import rv_mc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,  // >= 2
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  rv_mc_seq_if.master      mem,
  input  logic [6:0]       opcode_i,
  input  logic             branch_taken_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             alu_src_o,
  output logic             reg_write_o,
  output logic [1:0]       wb_sel_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t           state_q;
  logic [6:0]       opc_q;
  trap_cause_t      cause_q;
  logic [CNT_W-1:0] instret_q;
  logic             tmo_expire;

  rv_mc_seq_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .run_i    (mem.mem_req_o && !mem.mem_ack_i),
    .expire_o (tmo_expire)
  );

  // Sequencer state, latched opcode and trap cause.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_q <= ST_FETCH;
        ST_FETCH: begin
          if (mem.mem_ack_i) begin
            state_q <= ST_DECODE;
          end else if (tmo_expire) begin
            state_q <= ST_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          opc_q <= opcode_i;
          if (is_legal_opc(opcode_i)) begin
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end
        end
        ST_EXEC: begin
          if (opc_q == OPC_BRANCH)                           state_q <= ST_FETCH;
          else if (opc_q == OPC_LOAD || opc_q == OPC_STORE)  state_q <= ST_MEM;
          else                                               state_q <= ST_WB;
        end
        ST_MEM: begin
          if (mem.mem_ack_i) begin
            state_q <= (opc_q == OPC_LOAD) ? ST_WB : ST_FETCH;
          end else if (tmo_expire) begin
            state_q <= ST_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_WB:     state_q <= ST_FETCH;
        ST_TRAP:   state_q <= ST_TRAP;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Retired-instruction counter: one per PC update, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        instret_q <= '0;
    else if (pc_we_o) instret_q <= instret_q + CNT_W'(1);
  end

  // Per-state datapath strobes.
  always_comb begin
    mem.mem_req_o = 1'b0;
    mem.mem_we_o  = 1'b0;
    mem.mem_sel_o = 1'b0;
    ir_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    pc_src_o      = 1'b0;
    alu_src_o     = 1'b0;
    reg_write_o   = 1'b0;
    wb_sel_o      = WB_ALU;
    trap_o        = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem.mem_req_o = 1'b1;
        ir_we_o       = mem.mem_ack_i;
      end
      ST_EXEC: begin
        alu_src_o = uses_imm(opc_q);
        if (opc_q == OPC_BRANCH) begin
          pc_we_o  = 1'b1;
          pc_src_o = branch_taken_i;
        end
      end
      ST_MEM: begin
        mem.mem_req_o = 1'b1;
        mem.mem_sel_o = 1'b1;
        mem.mem_we_o  = (opc_q == OPC_STORE);
        alu_src_o     = 1'b1;
        // A store retires straight from MEM once the write completes.
        if (opc_q == OPC_STORE) pc_we_o = mem.mem_ack_i;
      end
      ST_WB: begin
        reg_write_o = 1'b1;
        if (opc_q == OPC_LOAD)     wb_sel_o = WB_MEM;
        else if (opc_q == OPC_JAL) wb_sel_o = WB_PC4;
        pc_we_o  = 1'b1;
        pc_src_o = (opc_q == OPC_JAL);
      end
      ST_TRAP:  trap_o = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_rv_mc_seq.sv
// Self-checking bench for rv_mc_seq: directed corner cases plus randomized
// instruction streams scored against a phase-level timing model.
module tb_rv_mc_seq;
  import rv_mc_seq_pkg::*;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [6:0]       opcode_i = '0;
  logic             branch_taken_i = 1'b0;
  logic             ir_we_o, pc_we_o, pc_src_o, alu_src_o, reg_write_o;
  logic [1:0]       wb_sel_o;
  logic             trap_o;
  logic [1:0]       trap_cause_o;
  logic [CNT_W-1:0] instret_o;

  rv_mc_seq_if mif ();

  rv_mc_seq #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem            (mif),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .pc_src_o       (pc_src_o),
    .alu_src_o      (alu_src_o),
    .reg_write_o    (reg_write_o),
    .wb_sel_o       (wb_sel_o),
    .trap_o         (trap_o),
    .trap_cause_o   (trap_cause_o),
    .instret_o      (instret_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  logic [6:0] legal_ops [0:5] = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All strobes plus trap flag and cause, packed for a one-shot idle check.
  function automatic logic [12:0] strobes();
    return {mif.mem_req_o, mif.mem_we_o, mif.mem_sel_o, ir_we_o, pc_we_o, pc_src_o,
            alu_src_o, reg_write_o, wb_sel_o, trap_o, trap_cause_o};
  endfunction

  // Reference model: instruction classes and phase lengths.
  function automatic bit is_mem(input logic [6:0] opc);
    return opc == OPC_LOAD || opc == OPC_STORE;
  endfunction
  function automatic bit writes_reg(input logic [6:0] opc);
    return opc == OPC_R || opc == OPC_I || opc == OPC_LOAD || opc == OPC_JAL;
  endfunction
  // fetch (fw+1) + decode + exec + optional data phase (mw+1) + optional writeback
  function automatic int model_latency(input logic [6:0] opc, input int fw, input int mw);
    return (fw + 1) + 1 + 1 + (is_mem(opc) ? mw + 1 : 0) + (writes_reg(opc) ? 1 : 0);
  endfunction

  // Hold reset for two cycles, release on a falling edge, check the IDLE cycle.
  task automatic do_reset();
    rstn = 1'b0;
    mif.mem_ack_i = 1'b0;
    exp_ret = 0;
    repeat (2) @(negedge clk);
    check("rst_strobes", 32'(strobes()), 32'd0);
    rstn = 1'b1;
    #1;
    check("idle_strobes", 32'(strobes()), 32'd0);
    check("idle_instret", 32'(instret_o), 32'd0);
  endtask

  // Run one instruction from its first FETCH cycle to its retire cycle, acting
  // as memory with fw/mw wait cycles before the fetch/data acks.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input logic taken);
    int   fcnt = 0, dcnt = 0, lat = 0, rw_cnt = 0, irw_cnt = 0, irw_cyc = 0;
    logic seen = 1'b0, pcsrc = 1'b0, mwe = 1'b0, alu_any = 1'b0;
    logic [1:0] wbsel = 2'b11;
    opcode_i       = opc;
    branch_taken_i = taken;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      @(negedge clk);
      mif.mem_ack_i = mif.mem_req_o &&
                      ((!mif.mem_sel_o && fcnt == fw) || (mif.mem_sel_o && dcnt == mw));
      #1;
      if (cyc == 0) check("instret_start", 32'(instret_o), 32'(exp_ret));
      if (mif.mem_req_o) begin
        if (mif.mem_sel_o) dcnt++; else fcnt++;
        if (mif.mem_we_o) mwe = 1'b1;
      end
      if (ir_we_o) begin irw_cnt++; irw_cyc = cyc + 1; end
      if (reg_write_o) begin rw_cnt++; wbsel = wb_sel_o; end
      alu_any |= alu_src_o;
      if (pc_we_o) begin seen = 1'b1; lat = cyc + 1; pcsrc = pc_src_o; end
    end
    @(posedge clk);
    #1 mif.mem_ack_i = 1'b0;
    check("retired", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(model_latency(opc, fw, mw)));
    check("ir_we_count", 32'(irw_cnt), 32'd1);
    check("ir_we_cycle", 32'(irw_cyc), 32'(fw + 1));
    check("fetch_req_cycles", 32'(fcnt), 32'(fw + 1));
    check("data_req_cycles", 32'(dcnt), is_mem(opc) ? 32'(mw + 1) : 32'd0);
    check("mem_we", 32'(mwe), 32'(opc == OPC_STORE));
    check("alu_src", 32'(alu_any), 32'(opc == OPC_I || is_mem(opc)));
    check("reg_write_count", 32'(rw_cnt), writes_reg(opc) ? 32'd1 : 32'd0);
    if (writes_reg(opc))
      check("wb_sel", 32'(wbsel),
            (opc == OPC_LOAD) ? 32'd1 : (opc == OPC_JAL) ? 32'd2 : 32'd0);
    check("pc_src", 32'(pcsrc),
          (opc == OPC_BRANCH) ? 32'(taken) : 32'(opc == OPC_JAL));
    exp_ret = (exp_ret + 1) % (1 << CNT_W);
  endtask

  initial begin
    int   trap_cyc;
    int   reqs;
    logic found;
    mif.mem_ack_i = 1'b0;
    #3;
    check("rst_async_strobes", 32'(strobes()), 32'd0);
    check("rst_async_instret", 32'(instret_o), 32'd0);
    do_reset();

    // Directed: one of each class with assorted waits, both branch outcomes.
    run_instr(OPC_R, 0, 0, 1'b0);
    run_instr(OPC_LOAD, 3, 3, 1'b0);
    run_instr(OPC_BRANCH, 0, 0, 1'b1);
    run_instr(OPC_BRANCH, 0, 0, 1'b0);
    run_instr(OPC_STORE, 1, 2, 1'b1);
    run_instr(OPC_JAL, 2, 0, 1'b0);
    run_instr(OPC_I, 0, 0, 1'b1);
    // Ack in the last allowed cycle of fetch and of data phase wins over timeout.
    run_instr(OPC_LOAD, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0);
    run_instr(OPC_STORE, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0);

    // Random stream from reset: crosses the 4-bit instret wrap.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, MEM_TIMEOUT - 1),
                $urandom_range(0, MEM_TIMEOUT - 1), 1'($urandom_range(0, 1)));
    end
    @(negedge clk); #1;
    check("instret_wrap", 32'(instret_o), 32'(22 % 16));

    // Illegal opcode: trap the cycle after DECODE, memory stays quiet.
    do_reset();
    opcode_i = 7'b1110011;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      mif.mem_ack_i = (cyc == 0) && mif.mem_req_o;
      #1;
      if (cyc == 1) check("illegal_decode_no_trap", 32'(trap_o), 32'd0);
      if (cyc >= 2) begin
        check("illegal_trap", 32'(trap_o), 32'd1);
        check("illegal_cause", 32'(trap_cause_o), 32'(CAUSE_ILLEGAL));
        check("illegal_quiet", 32'({mif.mem_req_o, pc_we_o, reg_write_o, ir_we_o}), 32'd0);
      end
    end
    #2 rstn = 1'b0;
    #1;
    check("trap_async_rst_strobes", 32'(strobes()), 32'd0);
    check("trap_async_rst_instret", 32'(instret_o), 32'd0);

    // Fetch timeout: MEM_TIMEOUT un-acked request cycles then trap cause 01.
    do_reset();
    opcode_i = OPC_R;
    trap_cyc = -1;
    reqs = 0;
    for (int cyc = 0; cyc < 40 && trap_cyc < 0; cyc++) begin
      @(negedge clk);
      mif.mem_ack_i = 1'b0;
      #1;
      if (trap_o) trap_cyc = cyc;
      else if (mif.mem_req_o) reqs++;
    end
    check("tmo_req_cycles", 32'(reqs), 32'(MEM_TIMEOUT));
    check("tmo_trap_cycle", 32'(trap_cyc), 32'(MEM_TIMEOUT));
    check("tmo_cause", 32'(trap_cause_o), 32'(CAUSE_TIMEOUT));
    check("tmo_req_low", 32'(mif.mem_req_o), 32'd0);

    // Reset asserted mid-MEM drops the request without a clock edge.
    do_reset();
    opcode_i = OPC_LOAD;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      mif.mem_ack_i = mif.mem_req_o && !mif.mem_sel_o;
      #1;
      if (mif.mem_req_o && mif.mem_sel_o) found = 1'b1;
    end
    check("mem_phase_reached", 32'(found), 32'd1);
    mif.mem_ack_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mem_async_rst_req", 32'(mif.mem_req_o), 32'd0);
    check("mem_async_rst_strobes", 32'(strobes()), 32'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
